// File: rtl/dff_stim_pkg.sv
// Shared types and default constants for the flip-flop stimulus generator.
package dff_stim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stim_state_t;

  localparam logic [7:0] DEF_TAPS_8 = 8'hB8;
  localparam logic [7:0] DEF_SEED_8 = 8'h01;

endpackage

// File: rtl/dff_stim_lfsr_gen_lfsr_core.sv
// Fibonacci LFSR with seed load; an all-zero seed is swapped for the default
// so the register can never lock up.
module lfsr_core import dff_stim_pkg::*; #(
  parameter int              W            = 8,
  parameter logic [W-1:0]    TAPS         = DEF_TAPS_8,
  parameter logic [W-1:0]    SEED_DEFAULT = DEF_SEED_8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  logic fb;

  assign fb = ^(state & TAPS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SEED_DEFAULT;
    end else if (load) begin
      state <= (load_val == '0) ? SEED_DEFAULT : load_val;
    end else if (step) begin
      state <= {state[W-2:0], fb};
    end
  end

endmodule

// File: rtl/dff_stim_lfsr_gen.sv
// Burst-mode pseudo-random bit source feeding a d flip-flop, with hold,
// reseed and a one-cycle done pulse when the burst has been emitted.
module dff_stim_lfsr_gen import dff_stim_pkg::*; #(
  parameter int                 LFSR_W       = 8,
  parameter logic [LFSR_W-1:0]  TAPS         = DEF_TAPS_8,
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = DEF_SEED_8,
  parameter int                 CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              hold,
  output logic              d_out,
  output logic              d_valid,
  output logic              busy,
  output logic              done
);

  stim_state_t       fsm_state, fsm_state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              d_out_n, d_valid_n, done_n;
  logic              lfsr_load, lfsr_step;
  logic [LFSR_W-1:0] lfsr;

  lfsr_core #(
    .W            (LFSR_W),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .state    (lfsr)
  );

  // A seed loaded together with start lands in the LFSR before the first
  // RUN cycle, so the first emitted bit is the new seed's MSB.
  always_comb begin
    fsm_state_n = fsm_state;
    count_n     = count;
    d_out_n     = d_out;
    d_valid_n   = 1'b0;
    done_n      = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    case (fsm_state)
      IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          if (burst_len == '0) begin
            fsm_state_n = DONE;
          end else begin
            fsm_state_n = RUN;
            count_n     = burst_len;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          d_out_n   = lfsr[LFSR_W-1];
          d_valid_n = 1'b1;
          lfsr_step = 1'b1;
          count_n   = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            fsm_state_n = DONE;
          end
        end
      end
      DONE: begin
        done_n      = 1'b1;
        fsm_state_n = IDLE;
      end
      default: fsm_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_state <= IDLE;
      count     <= '0;
      d_out     <= 1'b0;
      d_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      fsm_state <= fsm_state_n;
      count     <= count_n;
      d_out     <= d_out_n;
      d_valid   <= d_valid_n;
      done      <= done_n;
    end
  end

  assign busy = (fsm_state == RUN);

endmodule

// File: doc/dff_stim_lfsr_gen.md
Name: dff_stim_lfsr_gen

Overview:
- Hardware stimulus source that sits directly upstream of d_flip_flop and drives its d input with a pseudo-random bit stream.
- Replaces behavioural random generation with a synthesizable LFSR, so benches and FPGA bring-up use the same bit pattern.
- Emits a burst of programmable length on request, with pause and seed-reload control.
- Signals completion so a downstream checker can compare q against the delayed d.

Parameters:
- LFSR_W, 8, LFSR width in bits (minimum 3).
- TAPS, 8'hB8, feedback tap mask (x^8+x^6+x^5+x^4+1, maximal length for width 8).
- SEED_DEFAULT, 8'h01, reset and substitute seed; must be nonzero.
- CNT_W, 16, burst-length counter width.

Ports:
- clk  in  1  Clock; all logic on the rising edge.
- rst  in  1  Reset; synchronous, active-low (0 = reset, sampled only on the rising clk edge).
- seed_load  in  1  Load seed into the LFSR; honoured only in IDLE.
- seed  in  LFSR_W  Seed value.
- start  in  1  Begin a burst; honoured only in IDLE.
- burst_len  in  CNT_W  Number of bits to emit; sampled with start.
- hold  in  1  Pause emission while in RUN.
- d_out  out  1  Bit to the flip-flop d input.
- d_valid  out  1  High for one cycle per emitted bit.
- busy  out  1  High while in RUN.
- done  out  1  One-cycle pulse at the end of a burst.

Behaviour:
- Reset (rst=0 at a rising edge):
  - lfsr=SEED_DEFAULT, state=IDLE, count=0.
  - d_out=0, d_valid=0, busy=0, done=0.
  - Reset overrides all other inputs, including mid-burst; a partial burst is abandoned and no done pulse is issued.
- LFSR step (Fibonacci): fb = XOR-reduce(lfsr & TAPS); next lfsr = {lfsr[LFSR_W-2:0], fb}. The emitted bit is lfsr[LFSR_W-1] taken before the shift.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_load=1 loads lfsr=seed; a seed of 0 is replaced by SEED_DEFAULT, so the LFSR never locks up.
  - start=1 with burst_len!=0: count=burst_len, go to RUN, busy=1 from the next cycle.
  - start=1 with burst_len==0: go directly to DONE; no bits are emitted.
  - seed_load and start in the same cycle: the new seed is applied first, and the first emitted bit is seed[LFSR_W-1].
- RUN, hold=0:
  - Register d_out = lfsr MSB, d_valid=1, shift the LFSR, count--.
  - When the bit emitted has count==1, go to DONE.
- RUN, hold=1:
  - d_out holds its last value, d_valid=0.
  - lfsr and count are frozen; the burst resumes with no lost or duplicated bits.
- RUN ignores start and seed_load.
- DONE:
  - done=1 and busy=0 for exactly one cycle, d_valid=0, then return to IDLE.
  - The LFSR keeps its state, so the next burst continues the sequence unless reseeded.
- Latency:
  - start sampled at edge k → first d_valid visible after edge k+1 (when hold=0).
  - The last bit is emitted at edge k+N → done is visible after edge k+N+1.
- d_out holds its value outside d_valid cycles, and is therefore stable for the flip-flop between bursts.
- Counter: count is unsigned CNT_W bits. burst_len = 2^CNT_W-1 is legal. There is no wrap-around, because RUN exits at count==1.

Decomposition:
- Package dff_stim_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} stim_state_t;
  - localparams DEF_TAPS_8 = 8'hB8 and DEF_SEED_8 = 8'h01.
- Sub-module lfsr_core (ports clk, rst, load, load_val, step, state) holds the shift register and zero-seed substitution. The FSM and counter stay in the top module.

Test Plan:
- Reset, seed_load with seed=8'h01, then start with burst_len=8, hold=0 → d_out sequence 0,0,0,0,0,0,0,1 on 8 consecutive d_valid cycles; done pulses one cycle after the 8th bit; busy high for exactly 8 cycles.
- seed=8'h80, start with burst_len=1 → a single d_valid cycle with d_out=1, then done=1 on the next cycle, then IDLE.
- seed_load with seed=8'h00, then start with burst_len=8 → the same sequence as the first test (SEED_DEFAULT substituted).
- seed=8'h01, burst_len=8, hold=1 for 3 cycles after the 2nd bit → d_valid low for 3 cycles with d_out frozen at 0; the remaining bits are still 0,0,0,0,0,1; total d_valid count is 8.
- start with burst_len=0 → no d_valid; done pulses exactly once, 1 cycle after start; busy stays 0.
- Drive rst=0 during the 4th bit of an 8-bit burst → all outputs read 0 after the edge, state IDLE, no done pulse; the next start with burst_len=8 emits from SEED_DEFAULT.
